mdu_pipe: RTL and testbench

- Parametrised HI/LO multiply/divide unit for the MIPS pipeline; successor to the fixed 32-bit mult/div unit.
- Adds a configurable datapath width and separate per-class latencies.
- Adds multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) and defined divide-by-zero/overflow results.
- Sits in the EX stage. The hazard unit stalls HI/LO readers and any new md op while busy is high.

---
 rtl/mdu_pipe.sv | 197 +++++++++++++++++++
 tb/tb_mdu_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_pipe.sv
// HI/LO multiply/divide unit for the EX stage: MULT(U), DIV(U), MTHI/MTLO, MADD(U)/MSUB(U).
// Latency: MULT_LAT (mult/madd/msub class) or DIV_LAT (div class) edges from accept to HI/LO update; MTHI/MTLO update on the accept edge.
// Backpressure: busy is raised from the issue cycle until the commit edge; the hazard unit holds new md ops and HI/LO readers while it is high.
//
// Ports:
//   clk, reset      clock (rising edge), synchronous active-high reset
//   op_valid, op    md op strobe and 4-bit op code (10..15 are no-ops)
//   a, b            operands rs, rt
//   flush           cancels the in-flight op; only honoured when MDU_FLUSH_EN is defined
//   hi, lo          committed HI/LO registers
//   busy            combinational: issuing a mult/div/madd-class op from idle, or counting
//   done            one-cycle pulse, high the cycle after a HI/LO commit
//
// Optional feature macro: MDU_FLUSH_EN
module mdu_pipe #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     tmp_q, tmp_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;

    logic                   flush_w;

`ifdef MDU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
    logic unused_flush;
    assign unused_flush = flush;
`endif

    // Op classification
    logic is_md;
    logic mul_signed;
    always_comb begin
        is_md = (op == OP_MULT)  || (op == OP_MULTU) || (op == OP_DIV)  ||
                (op == OP_DIVU)  || (op == OP_MADD)  || (op == OP_MADDU) ||
                (op == OP_MSUB)  || (op == OP_MSUBU);
        mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    end

    // Multiply: extend operands to 2*WIDTH so the truncated product is the
    // exact mod-2^(2W) result for both signed and unsigned interpretations.
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
    always_comb begin
        a_ext = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;
        acc   = {hi_q, lo_q};
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. most-negative / -1 falls out
    // naturally: |a| = 2^(W-1), quotient negates back to a, remainder 0.
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, q_res, r_res;
    logic [2*WIDTH-1:0] div_res;
    always_comb begin
        a_neg = (op == OP_DIV) && a[WIDTH-1];
        b_neg = (op == OP_DIV) && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        q_res = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_res = a_neg ? -r_mag : r_mag;
        if (b == '0) begin
            div_res = {a, {WIDTH{1'b1}}};
        end else begin
            div_res = {r_res, q_res};
        end
    end

    // Next-state / output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmp_d   = tmp_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid && !flush_w) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU: begin
                            tmp_d   = prod;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                        end
                        OP_MADD, OP_MADDU: begin
                            tmp_d   = acc + prod;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                        end
                        OP_MSUB, OP_MSUBU: begin
                            tmp_d   = acc - prod;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            tmp_d   = div_res;
                            cnt_d   = DIV_CNT;
                            state_d = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // flush outranks a commit landing on the same edge
                if (flush_w) begin
                    cnt_d   = CNT_ZERO;
                    tmp_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    {hi_d, lo_d} = tmp_q;
                    cnt_d        = CNT_ZERO;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            tmp_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmp_q   <= tmp_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (op_valid && is_md && (state_q == S_IDLE)) || (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Self-checking bench for mdu_pipe: directed scenarios followed by random op streams against a timeline model.
// Latency: model commits a result LAT edges after its accept edge.
// Backpressure: model holds busy from issue until commit and drops ops presented meanwhile.
module tb_mdu_pipe;

    localparam int W        = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef MDU_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         op_valid = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    mdu_pipe #(.WIDTH(W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: a result waiting to land on a known edge number.
    logic [W-1:0]   m_hi = '0, m_lo = '0;
    logic [2*W-1:0] m_res = '0;
    bit             m_pend = 1'b0;
    bit             m_done = 1'b0;
    int             m_commit_edge = 0;
    int             edge_n = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_md(input logic [3:0] o);
        return (o <= 4'd3) || (o >= 4'd6 && o <= 4'd9);
    endfunction

    function automatic int lat_of(input logic [3:0] o);
        return (o == 4'd2 || o == 4'd3) ? DIV_LAT : MULT_LAT;
    endfunction

    function automatic logic [63:0] md_result(input logic [3:0] o, input logic [31:0] x,
                                              input logic [31:0] y, input logic [63:0] acc);
        longint          sp;
        longint unsigned up;
        int              q, r;
        sp = longint'($signed(x)) * longint'($signed(y));
        up = 64'(x) * 64'(y);
        case (o)
            4'd0: return 64'(sp);
            4'd1: return up;
            4'd6: return acc + 64'(sp);
            4'd7: return acc + up;
            4'd8: return acc - 64'(sp);
            4'd9: return acc - up;
            4'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            4'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_edge(input bit v, input logic [3:0] o, input logic [31:0] x,
                              input logic [31:0] y, input bit fl, input bit rst);
        bit fl_eff;
        bit nd;
        fl_eff = FLUSH_EN && fl;
        nd = 1'b0;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_pend = 1'b0; chk_en = 1'b1;
        end else if (m_pend) begin
            if (fl_eff) begin
                m_pend = 1'b0;
            end else if (edge_n == m_commit_edge) begin
                {m_hi, m_lo} = m_res;
                m_pend = 1'b0;
                nd = 1'b1;
            end
        end else if (v && !fl_eff) begin
            if (o == 4'd4) m_hi = x;
            else if (o == 4'd5) m_lo = x;
            else if (is_md(o)) begin
                m_res = md_result(o, x, y, {m_hi, m_lo});
                m_pend = 1'b1;
                m_commit_edge = edge_n + lat_of(o);
            end
        end
        m_done = nd;
        edge_n++;
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic drive(input bit v, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit fl, input bit rst);
        op_valid = v; op = o; a = x; b = y; flush = fl; reset = rst;
        @(negedge clk);
        if (chk_en) begin
            chk("busy", busy, m_pend || (v && is_md(o)));
            chk("hi",   hi,   m_hi);
            chk("lo",   lo,   m_lo);
            chk("done", done, m_done);
        end
        @(posedge clk);
        model_edge(v, o, x, y, fl, rst);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // reset
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_done", done, 1'b0);

        // MULT -2 * 3
        drive(1'b1, 4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        idle(5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_done", done, 1'b1);
        idle(1);

        // DIVU 100/7 with an MTLO presented mid-run
        drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 4'd5, 32'd55, 32'd0, 1'b0, 1'b0);
        idle(7);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        // DIV overflow and DIVU by zero
        drive(1'b1, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(10);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);
        drive(1'b1, 4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
        idle(10);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'd5);

        // MADDU / MSUB accumulate
        drive(1'b1, 4'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 32'd10, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 32'd4, 32'd5, 1'b0, 1'b0);
        idle(5);
        chk("maddu_lo", lo, 32'd30);
        chk("maddu_hi", hi, 32'd0);
        drive(1'b1, 4'd8, 32'd1, 32'd31, 1'b0, 1'b0);
        idle(5);
        chk("msub_lo", lo, 32'hFFFF_FFFF);
        chk("msub_hi", hi, 32'hFFFF_FFFF);

        // Reset in the middle of a MULT
        drive(1'b1, 4'd0, 32'd6, 32'd7, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
        chk("rstmid_hi", hi, 32'h0);
        chk("rstmid_lo", lo, 32'h0);
        chk("rstmid_busy", busy, 1'b0);
        idle(8);

        // Flush landing on the commit edge
        drive(1'b1, 4'd0, 32'd6, 32'd7, 1'b0, 1'b0);
        idle(4);
        drive(1'b0, 4'd0, '0, '0, 1'b1, 1'b0);
        idle(3);

        // Random op stream
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom % 2), 4'($urandom % 16), pick(), pick(),
                  ($urandom % 25) == 0, ($urandom % 200) == 0);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
